// File: rtl/mult_ctrl_taint_track_pkg.sv
// mult_ctrl_pkg: state encoding and counter sizing for the taint-tracking multiplier controller.
// Revision: 1.0
`default_nettype none

package mult_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_TEST  = 3'd2;
  localparam logic [2:0] ST_ADD   = 3'd3;
  localparam logic [2:0] ST_SHIFT = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult_ctrl_taint_tracker.sv
// mult_ctrl_taint_tracker: sticky control-flow taint register; TAINT_DECLASSIFY_EN clears it on DONE->IDLE.
// Revision: 1.0
`default_nettype none

module mult_ctrl_taint_tracker (
  input  logic clk,
  input  logic rst_n,
  input  logic in_idle,
  input  logic in_test,
  input  logic in_done,
  input  logic start_t,
  input  logic bit_t,
  output logic ctrl_taint
);

  logic ctrl_taint_d;
  logic ctrl_taint_q;

`ifdef TAINT_DECLASSIFY_EN
  always_comb begin
    ctrl_taint_d = ctrl_taint_q | (in_idle & start_t) | (in_test & bit_t);
    // DONE always returns to IDLE, so clearing here declassifies the next operation
    if (in_done) begin
      ctrl_taint_d = 1'b0;
    end
  end
`else
  logic unused_in_done;
  assign unused_in_done = in_done;

  always_comb begin
    ctrl_taint_d = ctrl_taint_q | (in_idle & start_t) | (in_test & bit_t);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_taint_q <= 1'b0;
    end else begin
      ctrl_taint_q <= ctrl_taint_d;
    end
  end

  assign ctrl_taint = ctrl_taint_q;

endmodule

`default_nettype wire

// File: rtl/mult_ctrl_taint_track.sv
// mult_ctrl_taint_track: shift-add multiplier sequencer with shadow taint on every control output.
// Revision: 1.0 -- optional macro TAINT_DECLASSIFY_EN (see mult_ctrl_taint_tracker)
`default_nettype none

module mult_ctrl_taint_track
  import mult_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             start_t,
  input  logic [WIDTH-1:0] multiplierReg,
  input  logic [WIDTH-1:0] multiplierReg_t,
  output logic             mdld,
  output logic             mrld,
  output logic             rsclear,
  output logic             rsload,
  output logic             rsshr,
  output logic             mdld_t,
  output logic             mrld_t,
  output logic             rsclear_t,
  output logic             rsload_t,
  output logic             rsshr_t,
  output logic             busy,
  output logic             busy_t,
  output logic             done,
  output logic             done_t
);

  localparam int              CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             ctrl_taint;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        cnt_d   = '0;
        state_d = ST_TEST;
      end
      ST_TEST: begin
        state_d = multiplierReg[cnt_q] ? ST_ADD : ST_SHIFT;
      end
      ST_ADD: begin
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_TEST;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Only the bit actually under test can steer control flow
  mult_ctrl_taint_tracker u_taint (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_idle    (state_q == ST_IDLE),
    .in_test    (state_q == ST_TEST),
    .in_done    (state_q == ST_DONE),
    .start_t    (start_t),
    .bit_t      (multiplierReg_t[cnt_q]),
    .ctrl_taint (ctrl_taint)
  );

  assign mdld    = (state_q == ST_INIT);
  assign mrld    = (state_q == ST_INIT);
  assign rsclear = (state_q == ST_INIT);
  assign rsload  = (state_q == ST_ADD);
  assign rsshr   = (state_q == ST_SHIFT);
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);

  assign mdld_t    = ctrl_taint & mdld;
  assign mrld_t    = ctrl_taint & mrld;
  assign rsclear_t = ctrl_taint & rsclear;
  assign rsload_t  = ctrl_taint & rsload;
  assign rsshr_t   = ctrl_taint & rsshr;
  assign busy_t    = ctrl_taint & busy;
  assign done_t    = ctrl_taint & done;

endmodule

`default_nettype wire

// File: tb/tb_mult_ctrl_taint_track.sv
// tb_mult_ctrl_taint_track: directed and randomized checks against a cycle-list reference model.
// Revision: 1.0
`default_nettype none

module tb_mult_ctrl_taint_track;

  localparam int W = 4;

  // Control vector order: {mdld, mrld, rsclear, rsload, rsshr, busy, done}
  localparam logic [6:0] V_IDLE  = 7'b0000000;
  localparam logic [6:0] V_INIT  = 7'b1110010;
  localparam logic [6:0] V_TEST  = 7'b0000010;
  localparam logic [6:0] V_ADD   = 7'b0001010;
  localparam logic [6:0] V_SHIFT = 7'b0000110;
  localparam logic [6:0] V_DONE  = 7'b0000011;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, start_t;
  logic [W-1:0] multiplierReg, multiplierReg_t;
  logic         mdld, mrld, rsclear, rsload, rsshr;
  logic         mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t;
  logic         busy, busy_t, done, done_t;

  int checks   = 0;
  int failures = 0;
  bit model_taint;

  always #5 clk = ~clk;

  mult_ctrl_taint_track #(.WIDTH(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .start_t         (start_t),
    .multiplierReg   (multiplierReg),
    .multiplierReg_t (multiplierReg_t),
    .mdld            (mdld),
    .mrld            (mrld),
    .rsclear         (rsclear),
    .rsload          (rsload),
    .rsshr           (rsshr),
    .mdld_t          (mdld_t),
    .mrld_t          (mrld_t),
    .rsclear_t       (rsclear_t),
    .rsload_t        (rsload_t),
    .rsshr_t         (rsshr_t),
    .busy            (busy),
    .busy_t          (busy_t),
    .done            (done),
    .done_t          (done_t)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic [6:0] ctrl_exp, input bit t);
    logic [13:0] obs, exp;
    obs = {mdld, mrld, rsclear, rsload, rsshr, busy, done,
           mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t, busy_t, done_t};
    exp = {ctrl_exp, ctrl_exp & {7{t}}};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected behaviour of one multiply as a list of per-cycle control vectors and taint values
  task automatic run_mul(input logic [W-1:0] m, input logic [W-1:0] mt,
                         input bit st_t, input bit noisy, input string tag);
    logic [6:0] q_ctrl[$];
    bit         q_t[$];
    bit         t;
    int         k;
    int         done_cycle;
    multiplierReg   = m;
    multiplierReg_t = mt;
    start           = 1'b1;
    start_t         = st_t;
    t = model_taint | st_t;
    k = 0;
    q_ctrl.push_back(V_INIT); q_t.push_back(t);
    for (int i = 0; i < W; i++) begin
      q_ctrl.push_back(V_TEST); q_t.push_back(t);
      if (mt[i]) t = 1'b1;
      if (m[i]) begin
        q_ctrl.push_back(V_ADD); q_t.push_back(t);
        k++;
      end
      q_ctrl.push_back(V_SHIFT); q_t.push_back(t);
    end
    q_ctrl.push_back(V_DONE); q_t.push_back(t);
`ifdef TAINT_DECLASSIFY_EN
    t = 1'b0;
`endif
    done_cycle = 0;
    foreach (q_ctrl[j]) begin
      step();
      check_outputs($sformatf("%s_cyc%0d", tag, j + 1), q_ctrl[j], q_t[j]);
      if (done === 1'b1) done_cycle = j + 1;
      if (noisy) begin
        start   = 1'($urandom_range(0, 1));
        start_t = 1'($urandom_range(0, 1));
      end else begin
        start   = 1'b0;
        start_t = 1'b0;
      end
    end
    model_taint = t;
    start   = 1'b0;
    start_t = 1'b0;
    checks++;
    assert (done_cycle == 2 + 2 * W + k) else begin
      failures++;
      $error("FAIL %s_latency observed=%0d expected=%0d", tag, done_cycle, 2 + 2 * W + k);
    end
    step();
    check_outputs({tag, "_idle"}, V_IDLE, 1'b0);
  endtask

  initial begin
    rst_n           = 1'b0;
    start           = 1'b0;
    start_t         = 1'b0;
    multiplierReg   = '0;
    multiplierReg_t = '0;
    model_taint     = 1'b0;
    step();
    step();
    check_outputs("reset", V_IDLE, 1'b0);
    rst_n = 1'b1;
    step();
    check_outputs("idle_after_reset", V_IDLE, 1'b0);

    run_mul(4'h5, 4'h0, 1'b0, 1'b0, "m5");
    run_mul(4'h0, 4'h0, 1'b0, 1'b0, "m0");
    run_mul(4'hF, 4'h0, 1'b0, 1'b0, "mF");
    run_mul(4'hF, 4'b0100, 1'b0, 1'b0, "mF_t2");

    // Reset asserted during an ADD cycle
    multiplierReg   = 4'h1;
    multiplierReg_t = 4'h0;
    start = 1'b1;
    step();
    check_outputs("rst_mid_init", V_INIT, model_taint);
    start = 1'b0;
    step();
    check_outputs("rst_mid_test", V_TEST, model_taint);
    step();
    check_outputs("rst_mid_add", V_ADD, model_taint);
    rst_n = 1'b0;
    step();
    check_outputs("rst_mid_cleared", V_IDLE, 1'b0);
    model_taint = 1'b0;
    rst_n = 1'b1;
    step();
    check_outputs("rst_mid_idle", V_IDLE, 1'b0);
    run_mul(4'h9, 4'h0, 1'b0, 1'b1, "after_rst");

    // Tainted start strobe with start low: no operation, but taint is recorded
    start   = 1'b0;
    start_t = 1'b1;
    step();
    check_outputs("idle_start_t", V_IDLE, 1'b0);
    model_taint = 1'b1;
    start_t = 1'b0;
    step();
    check_outputs("idle_start_t_hold", V_IDLE, 1'b0);
    run_mul(4'h3, 4'h0, 1'b0, 1'b0, "after_idle_taint");
    run_mul(4'h6, 4'h0, 1'b0, 1'b0, "follow_up");

    rst_n = 1'b0;
    step();
    check_outputs("reset2", V_IDLE, 1'b0);
    model_taint = 1'b0;
    rst_n = 1'b1;

    for (int n = 0; n < 24; n++) begin
      logic [W-1:0] m, mt;
      bit st;
      m  = W'($urandom);
      mt = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      st = ($urandom_range(0, 5) == 0);
      repeat ($urandom_range(0, 2)) begin
        step();
        check_outputs($sformatf("gap%0d", n), V_IDLE, 1'b0);
      end
      run_mul(m, mt, st, 1'b1, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
